fetch_stage: RTL

- IF stage plus IF/ID pipeline register, directly upstream of the ID-stage branch control.
- Owns the PC and issues word fetches on a req/ready instruction-memory port.
- Delivers pc_plus4_ID/inst_ID/valid_ID to ID.
- Consumes branch_address, is_branch and is_rst_IF_ID from branch control, and stall_IF_ID from the hazard unit.
- MIPS delay-slot semantics: the instruction at branch PC+4 is kept unless flushed.

---
 rtl/fetch_stage_pkg.sv | 17 +
 rtl/fetch_stage_if_id_reg.sv | 35 +++
 rtl/fetch_stage.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants and state encoding for the IF stage and its IF/ID register.
package fetch_stage_pkg;

    localparam logic        RST_ENABLE    = 1'b0;
    localparam logic        BRANCH_ENABLE = 1'b1;
    localparam int unsigned INST_ADDR_W   = 32;
    localparam int unsigned INST_DATA_W   = 32;
    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        DRAIN    = 2'd2,
        WAIT_BUF = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats stall; an unloaded, unstalled cycle inserts a bubble.
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   load,
    input  logic [INST_ADDR_W-1:0] pc_plus4_in,
    input  logic [INST_DATA_W-1:0] inst_in,
    output logic [INST_ADDR_W-1:0] pc_plus4_ID,
    output logic [INST_DATA_W-1:0] inst_ID,
    output logic                   valid_ID
);

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE || flush) begin
            pc_plus4_ID <= ZERO_WORD;
            inst_ID     <= ZERO_WORD;
            valid_ID    <= 1'b0;
        end else if (!stall) begin
            if (load) begin
                pc_plus4_ID <= pc_plus4_in;
                inst_ID     <= inst_in;
                valid_ID    <= 1'b1;
            end else begin
                pc_plus4_ID <= ZERO_WORD;
                inst_ID     <= ZERO_WORD;
                valid_ID    <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC sequencing, request FSM and a one-entry skid buffer feeding the IF/ID register.
// Handshake: a transfer happens on a cycle with inst_req && inst_ready; inst_req/inst_addr hold until then.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_IF_ID,
    input  logic [INST_ADDR_W-1:0] branch_address,
    input  logic                   is_branch,
    input  logic                   is_rst_IF_ID,
    output logic                   inst_req,
    output logic [INST_ADDR_W-1:0] inst_addr,
    input  logic                   inst_ready,
    input  logic [INST_DATA_W-1:0] inst_rdata,
    output logic [INST_ADDR_W-1:0] pc_plus4_ID,
    output logic [INST_DATA_W-1:0] inst_ID,
    output logic                   valid_ID,
    output fetch_state_t           state_dbg
);

    fetch_state_t           state, state_n;
    logic [INST_ADDR_W-1:0] req_addr, req_addr_n;
    logic [INST_ADDR_W-1:0] next_pc, next_pc_n;
    logic                   buf_valid, buf_valid_n;
    logic [INST_ADDR_W-1:0] buf_pc, buf_pc_n;
    logic [INST_DATA_W-1:0] buf_inst, buf_inst_n;

    logic                   xfer, branch_take, flush;
    logic                   buf_keep, xfer_keep, req_is_slot;
    logic [INST_ADDR_W-1:0] fetch_after;
    logic                   id_load;
    logic [INST_ADDR_W-1:0] id_pc4;
    logic [INST_DATA_W-1:0] id_inst;

    assign xfer        = inst_req && inst_ready;
    assign flush       = is_rst_IF_ID;
    assign branch_take = (is_branch == BRANCH_ENABLE) && !stall_IF_ID;
    assign req_is_slot = (req_addr == pc_plus4_ID);
    assign fetch_after = branch_take ? branch_address : next_pc;

    // Only the delay slot (address == pc_plus4_ID) survives a redirect; flush drops everything.
    assign buf_keep  = buf_valid && !flush && !(branch_take && buf_pc != pc_plus4_ID);
    assign xfer_keep = xfer && (state == REQ) && !flush && !(branch_take && !req_is_slot);

    always_comb begin
        id_load     = 1'b0;
        id_pc4      = buf_pc + 32'd4;
        id_inst     = buf_inst;
        buf_valid_n = buf_valid;
        buf_pc_n    = buf_pc;
        buf_inst_n  = buf_inst;
        if (flush) begin
            buf_valid_n = 1'b0;
        end else if (!stall_IF_ID) begin
            if (buf_keep) begin
                id_load     = 1'b1;
                buf_valid_n = xfer_keep;
                buf_pc_n    = req_addr;
                buf_inst_n  = inst_rdata;
            end else begin
                buf_valid_n = 1'b0;
                if (xfer_keep) begin
                    id_load = 1'b1;
                    id_pc4  = req_addr + 32'd4;
                    id_inst = inst_rdata;
                end
            end
        end else if (xfer_keep) begin
            buf_valid_n = 1'b1;
            buf_pc_n    = req_addr;
            buf_inst_n  = inst_rdata;
        end
    end

    always_comb begin
        state_n    = state;
        req_addr_n = req_addr;
        next_pc_n  = next_pc;
        inst_req   = 1'b0;
        case (state)
            IDLE, WAIT_BUF: begin
                if (branch_take) begin
                    req_addr_n = branch_address;
                    next_pc_n  = branch_address + 32'd4;
                end
                if (state == IDLE || !buf_valid_n) state_n = REQ;
            end
            REQ, DRAIN: begin
                inst_req = 1'b1;
                if (xfer) begin
                    req_addr_n = fetch_after;
                    next_pc_n  = fetch_after + 32'd4;
                    state_n    = buf_valid_n ? WAIT_BUF : REQ;
                end else begin
                    next_pc_n = fetch_after;
                    if (state == REQ && (flush || (branch_take && !req_is_slot)))
                        state_n = DRAIN;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state     <= IDLE;
            req_addr  <= RESET_PC;
            next_pc   <= RESET_PC + 32'd4;
            buf_valid <= 1'b0;
            buf_pc    <= ZERO_WORD;
            buf_inst  <= ZERO_WORD;
        end else begin
            state     <= state_n;
            req_addr  <= req_addr_n;
            next_pc   <= next_pc_n;
            buf_valid <= buf_valid_n;
            buf_pc    <= buf_pc_n;
            buf_inst  <= buf_inst_n;
        end
    end

    assign inst_addr = req_addr;
    assign state_dbg = state;

    if_id_reg u_if_id_reg (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall_IF_ID),
        .flush       (flush),
        .load        (id_load),
        .pc_plus4_in (id_pc4),
        .inst_in     (id_inst),
        .pc_plus4_ID (pc_plus4_ID),
        .inst_ID     (inst_ID),
        .valid_ID    (valid_ID)
    );

    a_no_buf_overflow : assert property (@(posedge clk) disable iff (rst == RST_ENABLE)
        !(buf_valid && stall_IF_ID && xfer_keep));

endmodule
